dm_resp: RTL and testbench

Data-memory responder for the multicycle MIPS core: the memory-side end of the request interface that the core's controller drives during its memory-access state. It accepts one word or byte access at a time, inserts a configurable number of wait states, performs the write or read on an internal word array, and returns read data with a one-cycle ready pulse. Byte reads are sign-extended (lb semantics); byte writes modify a single lane (sb semantics).

---
 rtl/dm_pkg.sv | 27 ++
 rtl/dm_lane.sv | 44 ++++
 rtl/dm_resp.sv | 153 +++++++++++++++
 tb/tb_dm_resp.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// byte-lane select values, default geometry and a sign-extension helper.
package dm_pkg;

  localparam int DEPTH_DEF = 1024;
  localparam int WAIT_DEF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dm_state_t;

  // Little-endian byte lanes within a 32-bit word
  localparam logic [1:0] LANE_0 = 2'd0;
  localparam logic [1:0] LANE_1 = 2'd1;
  localparam logic [1:0] LANE_2 = 2'd2;
  localparam logic [1:0] LANE_3 = 2'd3;

  // lb semantics: replicate bit 7 into the upper 24 bits
  function automatic logic signed [31:0] sext8(input logic signed [7:0] b);
    logic signed [31:0] r;
    r = b;
    return r;
  endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte-lane helper: extracts and sign-extends one lane for byte reads and
// merges a single byte into a word for byte writes. Purely combinational.
module dm_lane
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [7:0]  byte_in,
  output logic [31:0] rd_byte,
  output logic [31:0] merged
);

  logic signed [7:0] sel;

  // Lane select for the read path and lane replace for the write path
  always_comb begin
    sel    = word[7:0];
    merged = word;
    case (lane)
      LANE_0: begin
        sel    = word[7:0];
        merged = {word[31:8], byte_in};
      end
      LANE_1: begin
        sel    = word[15:8];
        merged = {word[31:16], byte_in, word[7:0]};
      end
      LANE_2: begin
        sel    = word[23:16];
        merged = {word[31:24], byte_in, word[15:0]};
      end
      LANE_3: begin
        sel    = word[31:24];
        merged = {byte_in, word[23:0]};
      end
      default: begin
        sel    = word[7:0];
        merged = word;
      end
    endcase
    rd_byte = sext8(sel);
  end

endmodule

// File: rtl/dm_resp.sv
// Data-memory responder: accepts one word/byte access at a time, waits a
// fixed number of cycles, then answers with a one-cycle ready pulse.
// Reads are resolved at the edge entering RESP; writes commit at the edge
// leaving RESP so a reset during RESP can still cancel them.
module dm_resp
  import dm_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WAIT  = WAIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic        lb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int          IDX_W    = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIM = 32'(DEPTH * 4);
  localparam logic [3:0]  CNT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  logic [31:0] mem [DEPTH];

  dm_state_t   state;
  logic [3:0]  cnt;

  // Request captured at acceptance
  logic        we_p1;
  logic        lb_p1;
  logic [31:0] addr_p1;
  logic [31:0] wdata_p1;

  // Effective request: live inputs while idle (needed when WAIT is 0 and the
  // response is produced at the accepting edge), latched copy otherwise
  logic        we_c;
  logic        lb_c;
  logic [31:0] addr_c;
  logic [31:0] wdata_c;
  logic        bad_c;
  logic [IDX_W-1:0] idx_c;
  logic [31:0] word_c;
  logic [31:0] rd_byte_c;
  logic [31:0] merged_c;
  logic [31:0] rd_val_c;
  logic        accept;
  logic        go_resp;

  // Select request source, decode legality and form the read value
  always_comb begin
    if (state == ST_IDLE) begin
      we_c    = we;
      lb_c    = lb;
      addr_c  = addr;
      wdata_c = wdata;
    end else begin
      we_c    = we_p1;
      lb_c    = lb_p1;
      addr_c  = addr_p1;
      wdata_c = wdata_p1;
    end
    bad_c    = ((!lb_c) && (addr_c[1:0] != 2'b00)) || (addr_c >= ADDR_LIM);
    idx_c    = addr_c[IDX_W+1:2];
    word_c   = mem[idx_c];
    rd_val_c = lb_c ? rd_byte_c : word_c;
    accept   = (state == ST_IDLE) && req;
    go_resp  = (accept && (WAIT == 0)) || ((state == ST_WAIT) && (cnt == 4'd0));
  end

  dm_lane u_lane (
    .word    (word_c),
    .lane    (addr_c[1:0]),
    .byte_in (wdata_c[7:0]),
    .rd_byte (rd_byte_c),
    .merged  (merged_c)
  );

  // Latch the request fields on acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p1    <= we;
      lb_p1    <= lb;
      addr_p1  <= addr;
      wdata_p1 <= wdata;
    end
  end

  // Control FSM: IDLE -> (WAIT) -> RESP -> IDLE, wait counter and busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            busy <= 1'b1;
            if (WAIT == 0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Response registers, loaded at the edge entering RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'h0;
    end else begin
      ready <= go_resp;
      err   <= go_resp && bad_c;
      if (go_resp && !we_c && !bad_c) begin
        rdata <= rd_val_c;
      end
    end
  end

  // Array write at the edge leaving RESP; err here is the latched rejection
  always_ff @(posedge clk) begin
    if (!rst && (state == ST_RESP) && we_p1 && !err) begin
      mem[idx_c] <= lb_p1 ? merged_c : wdata_p1;
    end
  end

endmodule

// File: tb/tb_dm_resp.sv
// Bench for dm_resp: two instances (WAIT=2/DEPTH=1024 and WAIT=0/DEPTH=64),
// directed scenarios plus randomized traffic against a word-array model.
module tb_dm_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_s   [2];
  logic        we_s    [2];
  logic        lb_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [31:0] rdata_s [2];
  logic        ready_s [2];
  logic        err_s   [2];
  logic        busy_s  [2];

  int total = 0;
  int bad   = 0;

  int depth_of [2] = '{1024, 64};
  int wait_of  [2] = '{2, 0};

  logic [31:0] mdl [int];
  logic [31:0] mrd [2];

  // Results of the last do_access
  int          lat;
  bit          e_o;
  bit          bok;
  bit          aok;
  bit          ee;
  logic [31:0] rd_o;
  logic [31:0] er;

  always #5 clk = ~clk;

  dm_resp #(.DEPTH(1024), .WAIT(2)) u_w2 (
    .clk(clk), .rst(rst), .req(req_s[0]), .we(we_s[0]), .lb(lb_s[0]),
    .addr(addr_s[0]), .wdata(wdata_s[0]), .rdata(rdata_s[0]),
    .ready(ready_s[0]), .err(err_s[0]), .busy(busy_s[0])
  );

  dm_resp #(.DEPTH(64), .WAIT(0)) u_w0 (
    .clk(clk), .rst(rst), .req(req_s[1]), .we(we_s[1]), .lb(lb_s[1]),
    .addr(addr_s[1]), .wdata(wdata_s[1]), .rdata(rdata_s[1]),
    .ready(ready_s[1]), .err(err_s[1]), .busy(busy_s[1])
  );

  function automatic bit m_bad(input int i, input bit b, input logic [31:0] a);
    return ((!b) && (a % 4 != 0)) || (a >= 32'(depth_of[i] * 4));
  endfunction

  // Apply one access to the model; produces expected rdata and err
  task automatic m_apply(input int i, input bit w, input bit b,
                         input logic [31:0] a, input logic [31:0] d);
    int k;
    int sh;
    logic [31:0] old;
    logic [31:0] v;
    ee = m_bad(i, b, a);
    k  = i * 65536 + int'(a / 4);
    sh = 8 * int'(a % 4);
    if (!ee) begin
      old = mdl.exists(k) ? mdl[k] : 32'h0;
      if (w) begin
        mdl[k] = b ? ((old & ~(32'hFF << sh)) | ((d & 32'hFF) << sh)) : d;
      end else begin
        v = b ? ((old >> sh) & 32'hFF) : old;
        if (b && v >= 32'h80) v = v | 32'hFFFFFF00;
        mrd[i] = v;
      end
    end
    er = mrd[i];
  endtask

  task automatic m_reset();
    mrd[0] = 32'h0;
    mrd[1] = 32'h0;
  endtask

  // Drive one request, wait for its response, capture what the DUT shows
  task automatic do_access(input int i, input bit w, input bit b,
                           input logic [31:0] a, input logic [31:0] d);
    m_apply(i, w, b, a, d);
    @(negedge clk);
    req_s[i] = 1'b1; we_s[i] = w; lb_s[i] = b; addr_s[i] = a; wdata_s[i] = d;
    @(posedge clk); #1;
    req_s[i] = 1'b0;
    bok = busy_s[i];
    lat = 0;
    while (!ready_s[i] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      bok = bok & busy_s[i];
    end
    if (!ready_s[i]) lat = -1;
    e_o  = err_s[i];
    rd_o = rdata_s[i];
    @(posedge clk); #1;
    aok = !ready_s[i] && !busy_s[i] && !err_s[i];
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      total++; if (ready_s[i] !== 1'b0) begin bad++; $display("FAIL rst_ready[%0d]: got %b want 0", i, ready_s[i]); end
      total++; if (err_s[i] !== 1'b0) begin bad++; $display("FAIL rst_err[%0d]: got %b want 0", i, err_s[i]); end
      total++; if (busy_s[i] !== 1'b0) begin bad++; $display("FAIL rst_busy[%0d]: got %b want 0", i, busy_s[i]); end
      total++; if (rdata_s[i] !== 32'h0) begin bad++; $display("FAIL rst_rdata[%0d]: got %h want 0", i, rdata_s[i]); end
    end
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_word_rw();
    do_access(0, 1'b1, 1'b0, 32'h10, 32'h12345678);
    total++; if (lat !== 2) begin bad++; $display("FAIL word_wr_lat: got %0d want 2", lat); end
    total++; if (e_o !== 1'b0) begin bad++; $display("FAIL word_wr_err: got %b want 0", e_o); end
    total++; if (!bok || !aok) begin bad++; $display("FAIL word_wr_busy: got busy_ok=%b after_ok=%b want 1 1", bok, aok); end
    do_access(0, 1'b0, 1'b0, 32'h10, 32'h0);
    total++; if (lat !== 2) begin bad++; $display("FAIL word_rd_lat: got %0d want 2", lat); end
    total++; if (rd_o !== 32'h12345678 || e_o !== 1'b0) begin bad++; $display("FAIL word_rd: got %h err %b want 12345678 err 0", rd_o, e_o); end
  endtask

  task automatic test_byte();
    do_access(0, 1'b1, 1'b0, 32'h20, 32'h11223344);
    do_access(0, 1'b1, 1'b1, 32'h21, 32'h123456AA);
    total++; if (e_o !== 1'b0) begin bad++; $display("FAIL sb_err: got %b want 0", e_o); end
    do_access(0, 1'b0, 1'b0, 32'h20, 32'h0);
    total++; if (rd_o !== 32'h1122AA44) begin bad++; $display("FAIL sb_word: got %h want 1122aa44", rd_o); end
    do_access(0, 1'b0, 1'b1, 32'h21, 32'h0);
    total++; if (rd_o !== 32'hFFFFFFAA) begin bad++; $display("FAIL lb_21: got %h want ffffffaa", rd_o); end
    do_access(0, 1'b0, 1'b1, 32'h23, 32'h0);
    total++; if (rd_o !== 32'h00000011) begin bad++; $display("FAIL lb_23: got %h want 00000011", rd_o); end
    do_access(0, 1'b0, 1'b1, 32'h20, 32'h0);
    total++; if (rd_o !== 32'h00000044) begin bad++; $display("FAIL lb_20: got %h want 00000044", rd_o); end
  endtask

  task automatic test_errors();
    do_access(0, 1'b0, 1'b0, 32'h22, 32'h0);
    total++; if (e_o !== 1'b1 || lat !== 2) begin bad++; $display("FAIL err_unaligned: got err %b lat %0d want err 1 lat 2", e_o, lat); end
    total++; if (rd_o !== 32'h00000044) begin bad++; $display("FAIL err_rdata_hold: got %h want 00000044", rd_o); end
    do_access(0, 1'b1, 1'b0, 32'h0, 32'hCAFEF00D);
    do_access(0, 1'b1, 1'b0, 32'h1000, 32'h01010101);
    total++; if (e_o !== 1'b1) begin bad++; $display("FAIL err_range_wr: got %b want 1", e_o); end
    do_access(0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (rd_o !== 32'hCAFEF00D) begin bad++; $display("FAIL err_no_corrupt: got %h want cafef00d", rd_o); end
    do_access(0, 1'b1, 1'b0, 32'hFFC, 32'h80000000);
    do_access(0, 1'b0, 1'b1, 32'hFFF, 32'h0);
    total++; if (rd_o !== 32'hFFFFFF80 || e_o !== 1'b0) begin bad++; $display("FAIL lb_last: got %h err %b want ffffff80 err 0", rd_o, e_o); end
    do_access(0, 1'b0, 1'b1, 32'h1000, 32'h0);
    total++; if (e_o !== 1'b1 || rd_o !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_range: got err %b rdata %h want err 1 rdata ffffff80", e_o, rd_o); end
  endtask

  task automatic test_wait0();
    do_access(1, 1'b1, 1'b0, 32'h4, 32'h0BADF00D);
    total++; if (lat !== 0 || e_o !== 1'b0) begin bad++; $display("FAIL w0_wr: got lat %0d err %b want lat 0 err 0", lat, e_o); end
    do_access(1, 1'b0, 1'b0, 32'h4, 32'h0);
    total++; if (lat !== 0 || rd_o !== 32'h0BADF00D) begin bad++; $display("FAIL w0_rd: got lat %0d rdata %h want lat 0 rdata 0badf00d", lat, rd_o); end
    total++; if (!aok) begin bad++; $display("FAIL w0_after: got after_ok %b want 1", aok); end
    @(negedge clk);
    req_s[1] = 1'b1; we_s[1] = 1'b0; lb_s[1] = 1'b0; addr_s[1] = 32'h4;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      total++;
      if (ready_s[1] !== (i % 2 == 0) || busy_s[1] !== ready_s[1] ||
          (ready_s[1] && rdata_s[1] !== 32'h0BADF00D)) begin
        bad++;
        $display("FAIL w0_held[%0d]: got ready %b busy %b rdata %h want ready %b busy %b rdata 0badf00d",
                 i, ready_s[1], busy_s[1], rdata_s[1], (i % 2 == 0), (i % 2 == 0));
      end
    end
    @(negedge clk);
    req_s[1] = 1'b0;
  endtask

  task automatic test_rst_mid();
    int n;
    do_access(0, 1'b1, 1'b0, 32'h30, 32'hDEADBEEF);
    do_access(0, 1'b0, 1'b0, 32'h30, 32'h0);
    total++; if (rd_o !== 32'hDEADBEEF) begin bad++; $display("FAIL rmid_seed: got %h want deadbeef", rd_o); end
    @(negedge clk);
    req_s[0] = 1'b1; we_s[0] = 1'b1; lb_s[0] = 1'b0; addr_s[0] = 32'h30; wdata_s[0] = 32'h55555555;
    @(posedge clk); #1;
    req_s[0] = 1'b0;
    total++; if (busy_s[0] !== 1'b1) begin bad++; $display("FAIL rmid_busy: got %b want 1", busy_s[0]); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    m_reset();
    total++;
    if (ready_s[0] !== 1'b0 || err_s[0] !== 1'b0 || busy_s[0] !== 1'b0 || rdata_s[0] !== 32'h0) begin
      bad++;
      $display("FAIL rmid_outputs: got ready %b err %b busy %b rdata %h want 0 0 0 0", ready_s[0], err_s[0], busy_s[0], rdata_s[0]);
    end
    total++; if (rdata_s[1] !== 32'h0) begin bad++; $display("FAIL rmid_rdata1: got %h want 0", rdata_s[1]); end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ready_s[0] || busy_s[0]) n++;
    end
    total++; if (n !== 0) begin bad++; $display("FAIL rmid_no_resp: got %0d active cycles want 0", n); end
    do_access(0, 1'b0, 1'b0, 32'h30, 32'h0);
    total++; if (rd_o !== 32'hDEADBEEF) begin bad++; $display("FAIL rmid_readback: got %h want deadbeef", rd_o); end
  endtask

  task automatic test_rst_resp();
    int n;
    @(negedge clk);
    req_s[0] = 1'b1; we_s[0] = 1'b1; lb_s[0] = 1'b0; addr_s[0] = 32'h30; wdata_s[0] = 32'h77777777;
    @(posedge clk); #1;
    req_s[0] = 1'b0;
    n = 0;
    while (!ready_s[0] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    total++; if (ready_s[0] !== 1'b1 || n !== 2) begin bad++; $display("FAIL rresp_ready: got ready %b after %0d want 1 after 2", ready_s[0], n); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    do_access(0, 1'b0, 1'b0, 32'h30, 32'h0);
    total++; if (rd_o !== 32'hDEADBEEF) begin bad++; $display("FAIL rresp_suppress: got %h want deadbeef", rd_o); end
  endtask

  task automatic test_rst_req();
    @(negedge clk);
    rst = 1'b1;
    req_s[0] = 1'b1; we_s[0] = 1'b1; lb_s[0] = 1'b0; addr_s[0] = 32'h0; wdata_s[0] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    m_reset();
    total++; if (busy_s[0] !== 1'b0 || ready_s[0] !== 1'b0) begin bad++; $display("FAIL rreq_edge: got busy %b ready %b want 0 0", busy_s[0], ready_s[0]); end
    @(negedge clk);
    rst = 1'b0;
    req_s[0] = 1'b0;
    @(posedge clk); #1;
    total++; if (busy_s[0] !== 1'b0) begin bad++; $display("FAIL rreq_idle: got busy %b want 0", busy_s[0]); end
    do_access(0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (rd_o !== 32'hCAFEF00D) begin bad++; $display("FAIL rreq_nowrite: got %h want cafef00d", rd_o); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    bit w;
    bit b;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 16; k++) begin
        do_access(i, 1'b1, 1'b0, 32'(k * 4), $urandom);
        total++; if (e_o !== 1'b0) begin bad++; $display("FAIL rnd_seed[%0d]: got err %b want 0", i, e_o); end
      end
    end
    for (int n = 0; n < 60; n++) begin
      int i;
      i = n % 2;
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = 32'(depth_of[i] * 4) + 32'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      do_access(i, w, b, a, $urandom);
      total++;
      if (lat !== wait_of[i] || e_o !== ee || rd_o !== er || !bok || !aok) begin
        bad++;
        $display("FAIL rnd[%0d] inst %0d we %b lb %b addr %h: got lat %0d err %b rdata %h busy_ok %b after_ok %b want lat %0d err %b rdata %h 1 1",
                 n, i, w, b, a, lat, e_o, rd_o, bok, aok, wait_of[i], ee, er);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_s[i] = 1'b0; we_s[i] = 1'b0; lb_s[i] = 1'b0; addr_s[i] = 32'h0; wdata_s[i] = 32'h0;
    end
    m_reset();
    test_reset();
    test_word_rw();
    test_byte();
    test_errors();
    test_wait0();
    test_rst_mid();
    test_rst_resp();
    test_rst_req();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
